// File: rtl/scan_index_gen_pkg.sv
// Shared definitions for the feature-map scan index generator:
// FSM encoding, default geometry and the read-address helper.
package scan_index_gen_pkg;

    localparam int unsigned DefWidth  = 64;
    localparam int unsigned DefHeight = 64;
    localparam int unsigned IdxW      = 10;
    localparam int unsigned AddrW     = 12;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StScan = 2'b01,
        StDone = 2'b10
    } scan_state_e;

    // Row-major address, deliberately truncated to the memory address width.
    function automatic logic [AddrW-1:0] rd_addr(input logic [IdxW-1:0] x,
                                                 input logic [IdxW-1:0] y,
                                                 input int unsigned     width);
        logic [31:0] full;
        full = 32'(y) * width + 32'(x);
        return full[AddrW-1:0];
    endfunction

endpackage

// File: rtl/scan_index_gen_if.sv
// Start/stall control and scan outputs of scan_index_gen, bundled as one interface.
interface scan_index_gen_if;
    import scan_index_gen_pkg::*;

    logic             i_start;
    logic             i_stall;
    logic [IdxW-1:0]  o_xIndex;
    logic [IdxW-1:0]  o_yIndex;
    logic [AddrW-1:0] o_rdAddr;
    logic             o_rdEn;
    logic             o_valid;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_stall,
        input  o_xIndex, o_yIndex, o_rdAddr, o_rdEn, o_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stall,
        output o_xIndex, o_yIndex, o_rdAddr, o_rdEn, o_valid, o_busy, o_done
    );

endinterface

// File: rtl/scan_xy_counter.sv
// Column/row wrap counter. Column P_WIDTH is an extra flush slot before each row wrap;
// the counter returns to 0,0 after the last slot of the frame.
module scan_xy_counter
    import scan_index_gen_pkg::*;
#(
    parameter int unsigned P_WIDTH  = DefWidth,
    parameter int unsigned P_HEIGHT = DefHeight
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_en,
    input  logic            i_clr,
    output logic [IdxW-1:0] o_x,
    output logic [IdxW-1:0] o_y,
    output logic            o_wrap,
    output logic            o_last
);

    logic [IdxW-1:0] x_q, x_d;
    logic [IdxW-1:0] y_q, y_d;

    assign o_x    = x_q;
    assign o_y    = y_q;
    assign o_wrap = (x_q == IdxW'(P_WIDTH));
    assign o_last = o_wrap && (y_q == IdxW'(P_HEIGHT - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_clr) begin
            x_d = '0;
            y_d = '0;
        end else if (i_en) begin
            if (o_wrap) begin
                x_d = '0;
                y_d = o_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/scan_index_gen.sv
// Frame scan sequencer: walks a P_WIDTH x P_HEIGHT feature map in raster order, issuing
// memory reads with a one-cycle-delayed valid, honouring downstream stalls.
module scan_index_gen
    import scan_index_gen_pkg::*;
#(
    parameter int unsigned P_WIDTH  = DefWidth,
    parameter int unsigned P_HEIGHT = DefHeight
) (
    input logic             i_clk,
    input logic             i_reset,
    scan_index_gen_if.slave bus
);

    scan_state_e     state_q, state_d;
    logic            valid_q;
    logic            rd_en;
    logic            cnt_en;
    logic            cnt_clr;
    logic [IdxW-1:0] x;
    logic [IdxW-1:0] y;
    logic            wrap;
    logic            last;

    assign cnt_en  = (state_q == StScan) && !bus.i_stall;
    assign cnt_clr = (state_q != StScan);
    // The wrap column is the flush slot, so no read is issued there.
    assign rd_en   = cnt_en && !wrap;

    scan_xy_counter #(
        .P_WIDTH  (P_WIDTH),
        .P_HEIGHT (P_HEIGHT)
    ) u_xy_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (cnt_en),
        .i_clr   (cnt_clr),
        .o_x     (x),
        .o_y     (y),
        .o_wrap  (wrap),
        .o_last  (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.i_start) state_d = StScan;
            StScan:  if (!bus.i_stall && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= rd_en;
        end
    end

    always_comb begin
        bus.o_xIndex = '0;
        bus.o_yIndex = '0;
        bus.o_rdAddr = rd_addr(x, y, P_WIDTH);
        bus.o_rdEn   = rd_en;
        bus.o_valid  = valid_q;
        bus.o_busy   = 1'b0;
        bus.o_done   = 1'b0;
        case (state_q)
            StScan: begin
                bus.o_xIndex = x;
                bus.o_yIndex = y;
                bus.o_busy   = 1'b1;
            end
            StDone:  bus.o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scan_index_gen.sv
// Scoreboard bench for scan_index_gen: a slot-count reference model predicts every cycle,
// a separate monitor pops and compares at the falling edge.
module tb_scan_index_gen;
    import scan_index_gen_pkg::*;

    localparam int W     = 64;
    localparam int H     = 64;
    localparam int Slots = H * (W + 1);

    typedef struct {
        int x;
        int y;
        bit rden;
        int addr;
        bit valid;
        bit busy;
        bit done;
    } exp_t;

    typedef enum int {MIdle, MScan, MDone} mmode_e;

    logic i_clk = 1'b0;
    logic i_reset;

    scan_index_gen_if bus ();

    scan_index_gen #(
        .P_WIDTH  (W),
        .P_HEIGHT (H)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    exp_t   exp_q[$];
    int     n_checks    = 0;
    int     n_pass      = 0;
    bit     mon_en      = 0;
    bit     tb_end      = 0;
    bit     drv_timeout = 0;

    // Reference model: position within the frame counted as a flat slot number.
    mmode_e m_mode    = MIdle;
    int     m_pos     = 0;
    bit     m_prev_rd = 0;

    function automatic exp_t model_out(input bit stall);
        exp_t e;
        e = '{default: 0};
        if (m_mode == MScan) begin
            e.x    = m_pos % (W + 1);
            e.y    = m_pos / (W + 1);
            e.busy = 1;
            e.rden = !stall && (e.x < W);
            e.addr = (e.y * W + e.x) % 4096;
        end else if (m_mode == MDone) begin
            e.done = 1;
        end
        e.valid = m_prev_rd;
        return e;
    endfunction

    task automatic model_step(input bit start, input bit stall, input bit rd);
        m_prev_rd = rd;
        case (m_mode)
            MIdle: if (start) begin
                m_mode = MScan;
                m_pos  = 0;
            end
            MScan: if (!stall) begin
                if (m_pos == Slots - 1) m_mode = MDone;
                else m_pos++;
            end
            default: m_mode = MIdle;
        endcase
    endtask

    task automatic drive(input bit start, input bit stall);
        exp_t e;
        bus.i_start = start;
        bus.i_stall = stall;
        e = model_out(stall);
        exp_q.push_back(e);
        @(posedge i_clk);
        model_step(start, stall, e.rden);
        #1;
    endtask

    // Reset is applied mid-cycle so the falling-edge sample sees its asynchronous effect.
    task automatic do_reset();
        exp_t e;
        i_reset     = 1'b0;
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        m_mode      = MIdle;
        m_pos       = 0;
        m_prev_rd   = 0;
        repeat (2) begin
            e = model_out(1'b0);
            exp_q.push_back(e);
            @(posedge i_clk);
            #1;
        end
        i_reset = 1'b1;
    endtask

    task automatic run_frame(input int stall_pct, input bit hold_start, input int reset_at,
                             input bit directed);
        int n        = 0;
        int here_cnt = 0;
        int last_pos = -1;
        bit stall;
        bit start;
        drive(1'b1, 1'b0);
        while (m_mode != MIdle && n < 20000) begin
            n++;
            if (reset_at >= 0 && m_mode == MScan && m_pos == reset_at) begin
                do_reset();
                return;
            end
            if (m_pos != last_pos) here_cnt = 0;
            last_pos = m_pos;
            if (directed && m_mode == MScan &&
                (m_pos == 2 * (W + 1) + 10 || m_pos == Slots - 1)) begin
                stall = (here_cnt < 5);
                if (stall) here_cnt++;
            end else begin
                stall = ($urandom_range(99) < stall_pct);
            end
            start = hold_start ? 1'b1 : 1'($urandom_range(1));
            drive(start, stall);
        end
        if (m_mode != MIdle) begin
            drv_timeout = 1;
            $display("FAIL frame_bound: model still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    initial begin : monitor
        exp_t e;
        int   rd_cnt    = 0;
        int   run_cnt   = 0;
        bit   busy_prev = 0;
        forever begin
            @(negedge i_clk);
            if (tb_end) begin
                chk("drive_bound", 32'(drv_timeout), 0);
                chk("queue_drained", exp_q.size(), 0);
            end else if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("queue_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("x_index", bus.o_xIndex, e.x);
                    chk("y_index", bus.o_yIndex, e.y);
                    chk("rd_en", bus.o_rdEn, 32'(e.rden));
                    chk("valid", bus.o_valid, 32'(e.valid));
                    chk("busy", bus.o_busy, 32'(e.busy));
                    chk("done", bus.o_done, 32'(e.done));
                    if (e.rden) chk("rd_addr", bus.o_rdAddr, e.addr);
                end
                if (bus.o_busy === 1'b1 && !busy_prev) begin
                    rd_cnt  = 0;
                    run_cnt = 0;
                end
                if (bus.o_busy === 1'b1) begin
                    if (bus.o_rdEn === 1'b1) rd_cnt++;
                    if (bus.i_stall === 1'b0) run_cnt++;
                end
                if (bus.o_done === 1'b1) begin
                    chk("frame_reads", rd_cnt, W * H);
                    chk("frame_scan_cycles", run_cnt, Slots);
                end
                busy_prev = (bus.o_busy === 1'b1);
            end
        end
    end

    initial begin : driver
        i_reset     = 1'b0;
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        @(posedge i_clk);
        #1;
        mon_en = 1;
        do_reset();
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        run_frame(0, 1'b0, -1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        run_frame(20, 1'b0, -1, 1'b1);
        drive(1'b0, 1'b0);
        run_frame(10, 1'b1, -1, 1'b0);
        run_frame(10, 1'b1, -1, 1'b0);
        drive(1'b0, 1'b0);
        run_frame(0, 1'b0, 40 * (W + 1) + 30, 1'b0);
        drive(1'b0, 1'b0);
        run_frame(0, 1'b0, -1, 1'b0);
        drive(1'b0, 1'b0);
        tb_end = 1;
        @(negedge i_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_index_gen.md
SCAN_INDEX_GEN -- requirements
Module: scan_index_gen

Interface
REQ-001 SHALL have parameter P_WIDTH, 64, columns per feature-map row.
REQ-002 SHALL have parameter P_HEIGHT, 64, rows per feature map.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  frame-start request, sampled in IDLE only.
REQ-006 SHALL have port i_stall  input  1  downstream back-pressure; freezes scan while high.
REQ-007 SHALL have port o_xIndex  output  10  current column index, 0..P_WIDTH.
REQ-008 SHALL have port o_yIndex  output  10  current row index, 0..P_HEIGHT-1.
REQ-009 SHALL have port o_rdAddr  output  12  feature-map memory read address.
REQ-010 SHALL have port o_rdEn  output  1  memory read strobe.
REQ-011 SHALL have port o_valid  output  1  memory data valid, o_rdEn delayed one cycle.
REQ-012 SHALL have port o_busy  output  1  high while in SCAN.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN and DONE; the encoding is 2 bits, and unused codes return to IDLE.
REQ-015 In IDLE, the block SHALL hold o_xIndex=0 and o_yIndex=0, with o_rdEn, o_busy and o_done all 0.
REQ-016 SHALL go IDLE->SCAN on the first edge with i_start=1; the indices remain 0,0 in that first SCAN cycle.
REQ-017 In SCAN with i_stall=0, the block SHALL increment x by 1 per cycle; at x==P_WIDTH, x wraps to 0 and y increments by 1.
REQ-018 Column x==P_WIDTH SHALL be a flush slot: the indices are presented, but o_rdEn=0 in that cycle.
REQ-019 o_rdEn SHALL equal (state==SCAN) & !i_stall & (x<P_WIDTH).
REQ-020 o_rdAddr SHALL equal y*P_WIDTH+x, truncated to 12 bits, and is don't-care when o_rdEn=0.
REQ-021 o_valid SHALL be o_rdEn registered one cycle, cleared on reset.
REQ-022 With i_stall=1, x, y and state SHALL hold, and o_rdEn SHALL be 0; o_valid for an already-issued read still asserts on the next cycle.
REQ-023 SCAN->DONE SHALL occur on the non-stalled edge where x==P_WIDTH and y==P_HEIGHT-1; a stall at that point delays the transition.
REQ-024 DONE SHALL last exactly one cycle with o_done=1 and indices forced to 0,0, then go to IDLE.
REQ-025 i_start SHALL be ignored in SCAN and DONE; i_start held high through DONE starts a new frame on the first IDLE edge.
REQ-026 o_busy SHALL be 1 exactly when state==SCAN.
REQ-027 One unstalled frame SHALL take P_HEIGHT*(P_WIDTH+1) SCAN cycles, i.e. 4160 at default parameters, plus 1 DONE cycle.
REQ-028 P_WIDTH*P_HEIGHT SHALL be at most 4096, and P_WIDTH SHALL be at most 1023; other values are illegal.

Reset
REQ-029 On i_reset=0, the block SHALL immediately force state=IDLE, x=0, y=0, o_valid=0, o_done=0, o_rdEn=0 and o_busy=0, regardless of clock.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no o_done pulse, and a new frame SHALL require a fresh i_start.

Structure
REQ-031 FSM state encodings and default P_WIDTH/P_HEIGHT SHALL live in the shared project package.
REQ-032 The x/y wrap counter SHALL be one sub-module, scan_xy_counter, with enable, wrap and last outputs; the FSM, address and valid logic stay in the top.

Verification
REQ-033 Reset, then i_start pulse with no stall -> o_busy high for 4160 cycles, o_rdEn high 4096 cycles, single o_done pulse, indices return to 0,0.
REQ-034 Row boundary -> at x=63,y=0 o_rdAddr=63; next cycle x=64, o_rdEn=0; next cycle x=0,y=1, o_rdAddr=64.
REQ-035 Stall 5 cycles at x=10,y=2 -> indices frozen at 10,2 with o_rdEn=0; the read issued just before the stall gives o_valid one cycle later; scan resumes at 10,2.
REQ-036 Stall asserted at x=64,y=63 -> no DONE until the stall releases, then o_done pulses exactly once.
REQ-037 Reset asserted at x=30,y=40 -> outputs zero asynchronously with no o_done; i_start then runs a full frame from 0,0.
REQ-038 i_start held continuously -> back-to-back frames with exactly one IDLE cycle between DONE and the next SCAN; i_start mid-frame has no effect.
